mips_mc_controller_hs: RTL and testbench

Next-generation multicycle MIPS main controller. Extends the existing load/jump-only FSM with stores, R-type, ADDI, BEQ/BNE, HALT and illegal-opcode trap. Adds a memory request/ready handshake with a bounded wait-state counter. Sits between the IR opcode field and the datapath/memory control inputs and drives all datapath mux/enable signals.

---
 rtl/mips_ctrl_pkg.sv | 71 +++++++
 rtl/mips_mc_controller_hs_timer.sv | 47 ++++
 rtl/mips_mc_controller_hs.sv | 203 ++++++++++++++++++++
 tb/tb_mips_mc_controller_hs.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, FSM states,
// ALU operation codes and datapath mux selects.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_RTYPE_EX  = 4'd7,
        S_RTYPE_WB  = 4'd8,
        S_IMM_EX    = 4'd9,
        S_IMM_WB    = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_HALT      = 4'd13,
        S_TRAP      = 4'd14
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] MM_WORD  = 2'b00;
    localparam logic [1:0] MM_SBYTE = 2'b01;
    localparam logic [1:0] MM_UBYTE = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic CAUSE_ILLEGAL = 1'b0;
    localparam logic CAUSE_TIMEOUT = 1'b1;

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_SB);
    endfunction

    // Byte ops of either direction use the signed-byte lane mode.
    function automatic logic [1:0] mem_mode_of(input logic [5:0] op);
        logic [1:0] mode;
        mode = MM_WORD;
        if ((op == OP_LB) || (op == OP_SB)) begin
            mode = MM_SBYTE;
        end else if (op == OP_LBU) begin
            mode = MM_UBYTE;
        end
        return mode;
    endfunction

endpackage

// File: rtl/mips_mc_controller_hs_timer.sv
// Wait-state counter for memory handshakes; flags a timeout when an access
// has waited WAIT_LIMIT cycles and mem_ready is still low.
module mips_mem_wait_timer #(
    parameter int WAIT_LIMIT = 16,
    parameter int WCNT_W     = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic start,
    input  logic mem_ready,
    output logic timeout
);

    localparam logic [WCNT_W-1:0] CNT_MAX = '1;

    logic [WCNT_W-1:0] cnt_reg;
    logic [WCNT_W-1:0] cnt_next;

    // Saturate instead of wrapping so an unbounded wait never aliases to a small count.
    always_comb begin
        cnt_next = cnt_reg;
        if (start || mem_ready || !active) begin
            cnt_next = '0;
        end else if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    generate
        if (WAIT_LIMIT > 0) begin : g_limit
            localparam logic [WCNT_W-1:0] LIMIT = WCNT_W'(WAIT_LIMIT);
            assign timeout = active && !mem_ready && (cnt_reg == LIMIT);
        end else begin : g_no_limit
            assign timeout = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/mips_mc_controller_hs.sv
// Multicycle MIPS main controller with memory request/ready handshake,
// wait-state timeout, HALT and illegal-opcode trap.
module mips_mc_controller_hs
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W    = 6,
    parameter int WAIT_LIMIT = 16,
    parameter int WCNT_W     = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               MemWrite,
    output logic [1:0]         MemMode,
    output logic               PCWriteCond,
    output logic               BranchNe,
    output logic               PCWrite,
    output logic [1:0]         PCSource,
    output logic               IorD,
    output logic               MemToReg,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOP,
    output logic               halted,
    output logic               trap,
    output logic               trap_cause
);

    state_t state_reg;
    state_t state_next;
    logic   cause_reg;
    logic   cause_next;
    logic   mem_state;
    logic   mem_entry;
    logic   timeout;

    assign mem_state = (state_reg == S_FETCH) || (state_reg == S_MEM_READ) ||
                       (state_reg == S_MEM_WRITE);
    assign mem_entry = ((state_next == S_FETCH) || (state_next == S_MEM_READ) ||
                        (state_next == S_MEM_WRITE)) && (state_next != state_reg);

    mips_mem_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT),
        .WCNT_W     (WCNT_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .active    (mem_state),
        .start     (mem_entry),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_RESET;
            cause_reg <= CAUSE_ILLEGAL;
        end else begin
            state_reg <= state_next;
            cause_reg <= cause_next;
        end
    end

    // Next state; mem_ready has priority over the timeout in every memory state.
    always_comb begin
        state_next = state_reg;
        cause_next = cause_reg;
        case (state_reg)
            S_RESET: state_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_next = S_DECODE;
                end else if (timeout) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB: state_next = S_MEM_ADDR;
                    OP_RTYPE:                           state_next = S_RTYPE_EX;
                    OP_ADDI:                            state_next = S_IMM_EX;
                    OP_BEQ, OP_BNE:                     state_next = S_BRANCH;
                    OP_J:                               state_next = S_JUMP;
                    OP_HALT:                            state_next = S_HALT;
                    default: begin
                        state_next = S_TRAP;
                        cause_next = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEM_ADDR: state_next = is_store(op) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ: begin
                if (mem_ready) begin
                    state_next = S_MEM_WB;
                end else if (timeout) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            S_MEM_WB:   state_next = S_FETCH;
            S_MEM_WRITE: begin
                if (mem_ready) begin
                    state_next = S_FETCH;
                end else if (timeout) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            S_RTYPE_EX: state_next = S_RTYPE_WB;
            S_RTYPE_WB: state_next = S_FETCH;
            S_IMM_EX:   state_next = S_IMM_WB;
            S_IMM_WB:   state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_JUMP:     state_next = S_FETCH;
            S_HALT:     state_next = S_HALT;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_RESET;
        endcase
    end

    always_comb begin
        mem_req     = 1'b0;
        MemWrite    = 1'b0;
        MemMode     = MM_WORD;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        PCWrite     = 1'b0;
        PCSource    = PCSRC_ALU;
        IorD        = 1'b0;
        MemToReg    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        ALUOP       = ALUOP_W'(ALU_ADD);
        halted      = 1'b0;
        trap        = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_req = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: ALUSrcB = SRCB_IMMSH;
            S_MEM_ADDR, S_IMM_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOP   = ALUOP_W'(ALU_ADD);
            end
            S_MEM_READ: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
                MemMode = mem_mode_of(op);
            end
            S_MEM_WB: begin
                MemToReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                MemWrite = 1'b1;
                MemMode  = mem_mode_of(op);
            end
            S_RTYPE_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_B;
                ALUOP   = ALUOP_W'(ALU_FUNCT);
            end
            S_RTYPE_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_IMM_WB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_B;
                ALUOP       = ALUOP_W'(ALU_SUB);
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                BranchNe    = (op == OP_BNE);
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            S_HALT:  halted = 1'b1;
            S_TRAP:  trap = 1'b1;
            default: ;
        endcase
    end

    assign trap_cause = cause_reg;

endmodule

// File: tb/tb_mips_mc_controller_hs.sv
// Scoreboard bench: each stimulus step queues the hand-derived output vector
// for that cycle; a negedge monitor pops and compares.
module tb_mips_mc_controller_hs;

    typedef struct packed {
        logic       mem_req;
        logic       memwrite;
        logic [1:0] memmode;
        logic       pcwritecond;
        logic       branchne;
        logic       pcwrite;
        logic [1:0] pcsource;
        logic       iord;
        logic       memtoreg;
        logic       irwrite;
        logic       regwrite;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [5:0] aluop;
        logic       halted;
        logic       trap;
    } outv_t;

    typedef struct packed {
        outv_t       v;
        logic        cause_care;
        logic        cause;
        logic [15:0] tag;
    } exp_t;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] LB   = 6'b100000;
    localparam logic [5:0] LBU  = 6'b100100;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] SB   = 6'b101000;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] HLT  = 6'b111111;
    localparam logic [5:0] ILL  = 6'b010001;

    localparam outv_t E_ZERO    = '{default: '0};
    localparam outv_t E_FETCH_W = '{mem_req: 1'b1, alusrcb: 2'b01, default: '0};
    localparam outv_t E_FETCH_R = '{mem_req: 1'b1, alusrcb: 2'b01, irwrite: 1'b1,
                                    pcwrite: 1'b1, default: '0};
    localparam outv_t E_DECODE  = '{alusrcb: 2'b11, default: '0};
    localparam outv_t E_MADDR   = '{alusrca: 1'b1, alusrcb: 2'b10, default: '0};
    localparam outv_t E_MRD_W   = '{mem_req: 1'b1, iord: 1'b1, default: '0};
    localparam outv_t E_MRD_B   = '{mem_req: 1'b1, iord: 1'b1, memmode: 2'b01, default: '0};
    localparam outv_t E_MRD_BU  = '{mem_req: 1'b1, iord: 1'b1, memmode: 2'b10, default: '0};
    localparam outv_t E_MWB     = '{memtoreg: 1'b1, regwrite: 1'b1, default: '0};
    localparam outv_t E_MWR_W   = '{mem_req: 1'b1, iord: 1'b1, memwrite: 1'b1, default: '0};
    localparam outv_t E_MWR_B   = '{mem_req: 1'b1, iord: 1'b1, memwrite: 1'b1,
                                    memmode: 2'b01, default: '0};
    localparam outv_t E_RTEX    = '{alusrca: 1'b1, aluop: 6'd2, default: '0};
    localparam outv_t E_RTWB    = '{regwrite: 1'b1, regdst: 1'b1, default: '0};
    localparam outv_t E_IMMWB   = '{regwrite: 1'b1, default: '0};
    localparam outv_t E_BNE     = '{alusrca: 1'b1, aluop: 6'd1, pcwritecond: 1'b1,
                                    pcsource: 2'b01, branchne: 1'b1, default: '0};
    localparam outv_t E_BEQ     = '{alusrca: 1'b1, aluop: 6'd1, pcwritecond: 1'b1,
                                    pcsource: 2'b01, default: '0};
    localparam outv_t E_JUMP    = '{pcwrite: 1'b1, pcsource: 2'b10, default: '0};
    localparam outv_t E_HALT    = '{halted: 1'b1, default: '0};
    localparam outv_t E_TRAP    = '{trap: 1'b1, default: '0};

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       mem_ready;
    logic       mem_req, MemWrite, PCWriteCond, BranchNe, PCWrite, IorD;
    logic       MemToReg, IRWrite, RegWrite, RegDst, ALUSrcA;
    logic [1:0] MemMode, PCSource, ALUSrcB;
    logic [5:0] ALUOP;
    logic       halted, trap, trap_cause;

    exp_t        sb_q[$];
    int          total;
    int          bad;
    int unsigned tag_cnt;
    exp_t        mon_e;
    outv_t       mon_got;

    mips_mc_controller_hs #(
        .ALUOP_W    (6),
        .WAIT_LIMIT (4),
        .WCNT_W     (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .MemWrite    (MemWrite),
        .MemMode     (MemMode),
        .PCWriteCond (PCWriteCond),
        .BranchNe    (BranchNe),
        .PCWrite     (PCWrite),
        .PCSource    (PCSource),
        .IorD        (IorD),
        .MemToReg    (MemToReg),
        .IRWrite     (IRWrite),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOP       (ALUOP),
        .halted      (halted),
        .trap        (trap),
        .trap_cause  (trap_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e   = sb_q.pop_front();
            mon_got = {mem_req, MemWrite, MemMode, PCWriteCond, BranchNe, PCWrite, PCSource,
                       IorD, MemToReg, IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOP,
                       halted, trap};
            total++;
            if (mon_got !== mon_e.v) begin
                bad++;
                $display("FAIL outputs step %0d got=%h want=%h", mon_e.tag, mon_got, mon_e.v);
            end else begin
                $display("step %0d outputs=%h ok", mon_e.tag, mon_got);
            end
            if (mon_e.cause_care) begin
                total++;
                if (trap_cause !== mon_e.cause) begin
                    bad++;
                    $display("FAIL trap_cause step %0d got=%b want=%b",
                             mon_e.tag, trap_cause, mon_e.cause);
                end
            end
        end
    end

    // Inputs applied here act at the next edge; v is what the DUT shows now.
    task automatic step(input logic r, input logic rdy, input logic [5:0] o,
                        input outv_t v, input logic care, input logic cause);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = r;
        mem_ready = rdy;
        op        = o;
        e.v          = v;
        e.cause_care = care;
        e.cause      = cause;
        e.tag        = 16'(tag_cnt);
        sb_q.push_back(e);
        tag_cnt++;
    endtask

    task automatic s(input logic rdy, input logic [5:0] o, input outv_t v);
        step(1'b0, rdy, o, v, 1'b0, 1'b0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        tag_cnt   = 0;
        reset     = 1'b1;
        mem_ready = 1'b0;
        op        = LW;

        step(1'b1, 1'b1, LW, E_ZERO, 1'b0, 1'b0);
        s(1'b1, LW, E_ZERO);
        // LW with zero wait states
        s(1'b1, LW, E_FETCH_R); s(1'b1, LW, E_DECODE); s(1'b1, LW, E_MADDR);
        s(1'b1, LW, E_MRD_W);   s(1'b1, LW, E_MWB);
        // fetch stalls three cycles, then SB with two wait states
        for (int i = 0; i < 3; i++) s(1'b0, SB, E_FETCH_W);
        s(1'b1, SB, E_FETCH_R); s(1'b1, SB, E_DECODE); s(1'b1, SB, E_MADDR);
        s(1'b0, SB, E_MWR_B);   s(1'b0, SB, E_MWR_B);  s(1'b1, SB, E_MWR_B);
        // BNE
        s(1'b1, BNE, E_FETCH_R); s(1'b1, BNE, E_DECODE); s(1'b1, BNE, E_BNE);
        // BEQ with ready arriving in the limit cycle
        for (int i = 0; i < 4; i++) s(1'b0, BEQ, E_FETCH_W);
        s(1'b1, BEQ, E_FETCH_R); s(1'b1, BEQ, E_DECODE); s(1'b1, BEQ, E_BEQ);
        // R-type, ADDI, J
        s(1'b1, RT, E_FETCH_R);   s(1'b1, RT, E_DECODE);   s(1'b1, RT, E_RTEX);
        s(1'b1, RT, E_RTWB);
        s(1'b1, ADDI, E_FETCH_R); s(1'b1, ADDI, E_DECODE); s(1'b1, ADDI, E_MADDR);
        s(1'b1, ADDI, E_IMMWB);
        s(1'b1, JMP, E_FETCH_R);  s(1'b1, JMP, E_DECODE);  s(1'b1, JMP, E_JUMP);
        // LB, LBU, SW
        s(1'b1, LB, E_FETCH_R);  s(1'b1, LB, E_DECODE);  s(1'b1, LB, E_MADDR);
        s(1'b1, LB, E_MRD_B);    s(1'b1, LB, E_MWB);
        s(1'b1, LBU, E_FETCH_R); s(1'b1, LBU, E_DECODE); s(1'b1, LBU, E_MADDR);
        s(1'b1, LBU, E_MRD_BU);  s(1'b1, LBU, E_MWB);
        s(1'b1, SW, E_FETCH_R);  s(1'b1, SW, E_DECODE);  s(1'b1, SW, E_MADDR);
        s(1'b1, SW, E_MWR_W);
        // LW read never acknowledged: four counted waits, trap in the limit cycle
        s(1'b1, LW, E_FETCH_R); s(1'b1, LW, E_DECODE); s(1'b1, LW, E_MADDR);
        for (int i = 0; i < 5; i++) s(1'b0, LW, E_MRD_W);
        step(1'b0, 1'b1, LW, E_TRAP, 1'b1, 1'b1);
        step(1'b0, 1'b0, LW, E_TRAP, 1'b1, 1'b1);
        step(1'b0, 1'b1, LW, E_TRAP, 1'b1, 1'b1);
        step(1'b1, 1'b1, ILL, E_TRAP, 1'b1, 1'b1);
        s(1'b1, ILL, E_ZERO);
        // illegal opcode
        s(1'b1, ILL, E_FETCH_R); s(1'b1, ILL, E_DECODE);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, ILL, E_TRAP, 1'b1, 1'b0);
        step(1'b1, 1'b1, ILL, E_TRAP, 1'b1, 1'b0);
        s(1'b1, HLT, E_ZERO);
        // HALT is sticky and ignores mem_ready
        s(1'b1, HLT, E_FETCH_R); s(1'b1, HLT, E_DECODE);
        for (int i = 0; i < 12; i++) s(1'(i % 2), HLT, E_HALT);
        step(1'b1, 1'b0, LW, E_HALT, 1'b0, 1'b0);
        // reset in the middle of a fetch abandons it
        s(1'b0, LW, E_ZERO);
        s(1'b0, LW, E_FETCH_W);
        step(1'b1, 1'b0, LW, E_FETCH_W, 1'b0, 1'b0);
        s(1'b0, LW, E_ZERO);

        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d want=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
